// File: rtl/hdmi_timing_gen.sv
// hdmi_timing_gen
//   Video timing generator for a DVI/HDMI transmitter. Two free-running
//   counters (cnt_h, cnt_v) walk the raster in the order sync, back porch,
//   active, front porch, both horizontally and vertically. Every output is a
//   combinational decode of those counters, en and reset.
//
// Ports
//   clk_in      in   1   pixel clock
//   sys_rst_n   in   1   asynchronous active-low reset
//   en          in   1   timing enable (0 parks the raster at the origin)
//   pix_data    in  24   {R,G,B} from the pixel source, one clock after data_req
//   hsync       out  1   active-high horizontal sync
//   vsync       out  1   active-high vertical sync
//   rgb_valid   out  1   active video window
//   data_req    out  1   pixel request, one clock ahead of rgb_valid
//   pix_x       out 12   column of the requested pixel (0 when not requesting)
//   pix_y       out 12   row of the requested pixel (0 when not requesting)
//   rgb_r/g/b   out  8   pix_data gated by rgb_valid
//   frame_start out  1   one-clock pulse at cnt_h=0, cnt_v=0
module hdmi_timing_gen #(
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int H_VALID = 640,
  parameter int H_FRONT = 16,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_VALID = 480,
  parameter int V_FRONT = 10
) (
  input  logic        clk_in,
  input  logic        sys_rst_n,
  input  logic        en,
  input  logic [23:0] pix_data,
  output logic        hsync,
  output logic        vsync,
  output logic        rgb_valid,
  output logic        data_req,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic [7:0]  rgb_r,
  output logic [7:0]  rgb_g,
  output logic [7:0]  rgb_b,
  output logic        frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

  localparam logic [11:0] H_MAX     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_MAX     = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_SYNC_E  = 12'(H_SYNC);
  localparam logic [11:0] V_SYNC_E  = 12'(V_SYNC);
  localparam logic [11:0] H_ACT_B   = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] H_ACT_E   = 12'(H_SYNC + H_BACK + H_VALID);
  // Request window is the active window moved one clock earlier on the line.
  localparam logic [11:0] H_REQ_B   = 12'(H_SYNC + H_BACK - 1);
  localparam logic [11:0] H_REQ_E   = 12'(H_SYNC + H_BACK + H_VALID - 1);
  localparam logic [11:0] V_ACT_B   = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] V_ACT_E   = 12'(V_SYNC + V_BACK + V_VALID);

  logic [11:0] cnt_h;
  logic [11:0] cnt_v;

  // Raster counters; en=0 parks them at the origin so the next enabled
  // clock is the first clock of a fresh frame.
  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_h <= '0;
      cnt_v <= '0;
    end else if (!en) begin
      cnt_h <= '0;
      cnt_v <= '0;
    end else if (cnt_h == H_MAX) begin
      cnt_h <= '0;
      cnt_v <= (cnt_v == V_MAX) ? 12'd0 : cnt_v + 12'd1;
    end else begin
      cnt_h <= cnt_h + 12'd1;
    end
  end

  logic run;
  logic v_win;

  // Reset is folded into the gate because the counters sit at the origin
  // during reset, which would otherwise decode as sync/frame_start.
  assign run = en & sys_rst_n;

  always_comb begin
    hsync       = 1'b0;
    vsync       = 1'b0;
    rgb_valid   = 1'b0;
    data_req    = 1'b0;
    pix_x       = '0;
    pix_y       = '0;
    frame_start = 1'b0;
    v_win       = (cnt_v >= V_ACT_B) && (cnt_v < V_ACT_E);
    if (run) begin
      hsync       = (cnt_h < H_SYNC_E);
      vsync       = (cnt_v < V_SYNC_E);
      rgb_valid   = v_win && (cnt_h >= H_ACT_B) && (cnt_h < H_ACT_E);
      data_req    = v_win && (cnt_h >= H_REQ_B) && (cnt_h < H_REQ_E);
      frame_start = (cnt_h == 12'd0) && (cnt_v == 12'd0);
      if (data_req) begin
        pix_x = cnt_h - H_REQ_B;
        pix_y = cnt_v - V_ACT_B;
      end
    end
    {rgb_r, rgb_g, rgb_b} = rgb_valid ? pix_data : 24'd0;
  end

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Bench for hdmi_timing_gen using a reduced raster so several whole frames
// fit in a short run. The reference tracks only the number of clocks since
// the frame origin and derives position and every output from it.
module tb_hdmi_timing_gen;

  localparam int HS = 5, HB = 3, HV = 8, HF = 2;
  localparam int VS = 2, VB = 3, VV = 4, VF = 2;
  localparam int HT = HS + HB + HV + HF;   // 18
  localparam int VT = VS + VB + VV + VF;   // 11
  localparam int FT = HT * VT;             // 198

  logic        clk_in = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        en = 1'b0;
  logic [23:0] pix_data = '0;
  logic        hsync, vsync, rgb_valid, data_req, frame_start;
  logic [11:0] pix_x, pix_y;
  logic [7:0]  rgb_r, rgb_g, rgb_b;

  hdmi_timing_gen #(
    .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_FRONT(VF)
  ) dut (
    .clk_in(clk_in), .sys_rst_n(sys_rst_n), .en(en), .pix_data(pix_data),
    .hsync(hsync), .vsync(vsync), .rgb_valid(rgb_valid), .data_req(data_req),
    .pix_x(pix_x), .pix_y(pix_y), .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
    .frame_start(frame_start)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Reference state: clocks elapsed since the frame origin.
  int t = 0;
  int prev_exp_x = 0;
  logic        e_hs, e_vs, e_valid, e_req, e_fs;
  int          e_x, e_y;
  logic [23:0] e_rgb;

  function automatic logic [23:0] ramp(input int x);
    logic [7:0] b;
    b = 8'(x);
    return {b, b + 8'd85, ~b};
  endfunction

  task automatic calc();
    int h, v;
    logic act, vwin;
    h = t % HT;
    v = t / HT;
    act = en && sys_rst_n;
    vwin = (v >= VS + VB) && (v < VS + VB + VV);
    e_hs    = act && (h < HS);
    e_vs    = act && (v < VS);
    e_valid = act && vwin && (h >= HS + HB) && (h < HS + HB + HV);
    // pixel requested now is the one shown on the next clock
    e_req   = act && vwin && (h + 1 >= HS + HB) && (h + 1 < HS + HB + HV);
    e_x     = e_req ? (h + 1) - (HS + HB) : 0;
    e_y     = e_req ? v - (VS + VB) : 0;
    e_fs    = act && (t == 0);
    e_rgb   = e_valid ? ramp(prev_exp_x) : 24'd0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic check_all();
    calc();
    chk("hsync", 32'(hsync), 32'(e_hs));
    chk("vsync", 32'(vsync), 32'(e_vs));
    chk("rgb_valid", 32'(rgb_valid), 32'(e_valid));
    chk("data_req", 32'(data_req), 32'(e_req));
    chk("pix_x", 32'(pix_x), 32'(e_x));
    chk("pix_y", 32'(pix_y), 32'(e_y));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("rgb", 32'({rgb_r, rgb_g, rgb_b}), 32'(e_rgb));
  endtask

  // One clock: the pixel source answers the request seen at the edge.
  task automatic step();
    int p_x;
    logic d_req;
    logic [11:0] d_x;
    calc();
    p_x = e_x;
    d_req = data_req;
    d_x = pix_x;
    @(posedge clk_in);
    if (!sys_rst_n || !en) t = 0;
    else t = (t + 1) % FT;
    prev_exp_x = p_x;
    #1 pix_data = d_req ? ramp(int'(d_x)) : 24'($urandom);
    @(negedge clk_in);
    check_all();
  endtask

  int n_fs, n_hs, n_vs, n_val, n;
  logic found;

  initial begin
    // Reset held, outputs quiet whatever en does.
    @(negedge clk_in);
    check_all();
    en = 1'b1;
    #1 check_all();
    step();
    step();

    // Release between edges: origin presented at once.
    @(negedge clk_in);
    #2 sys_rst_n = 1'b1;
    #1 check_all();

    // Two whole frames with aggregate counts.
    n_fs = 0; n_hs = 0; n_vs = 0; n_val = 0;
    for (int i = 0; i < 2 * FT; i++) begin
      step();
      n_fs  += int'(frame_start);
      n_hs  += int'(hsync);
      n_vs  += int'(vsync);
      n_val += int'(rgb_valid);
    end
    chk("frame_start_count", 32'(n_fs), 32'd2);
    chk("hsync_count", 32'(n_hs), 32'(2 * VT * HS));
    chk("vsync_count", 32'(n_vs), 32'(2 * VS * HT));
    chk("valid_count", 32'(n_val), 32'(2 * VV * HV));

    // Drop en for 50 clocks in the middle of an active line.
    found = 1'b0;
    for (int i = 0; i < 2 * FT && !found; i++) begin
      step();
      found = e_valid && ((t % HT) == HS + HB + 3);
    end
    chk("find_active", 32'(found), 32'd1);
    en = 1'b0;
    #1 check_all();
    repeat (50) step();
    en = 1'b1;
    #1 check_all();
    chk("restart_fs", 32'(frame_start), 32'd1);
    chk("restart_hs", 32'(hsync), 32'd1);
    chk("restart_vs", 32'(vsync), 32'd1);

    // Asynchronous reset in the middle of an active row.
    found = 1'b0;
    for (int i = 0; i < 2 * FT && !found; i++) begin
      step();
      found = (t / HT == VS + VB + 1) && ((t % HT) == HS + HB + 2);
    end
    chk("find_row", 32'(found), 32'd1);
    #2 sys_rst_n = 1'b0;
    t = 0;
    #1 check_all();
    repeat (3) begin
      en = 1'($urandom);
      step();
    end
    en = 1'b1;
    #2 sys_rst_n = 1'b1;
    #1 check_all();
    repeat (FT + 7) step();

    // Randomized runs with en gaps.
    repeat (8) begin
      n = $urandom_range(10, 300);
      repeat (n) step();
      en = 1'b0;
      #1 check_all();
      n = $urandom_range(1, 50);
      repeat (n) step();
      en = 1'b1;
      #1 check_all();
    end
    repeat (FT) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
